// File: rtl/pconv_line_buf_if.sv
// pconv_line_buf_if: start/layer control, sample input and window output handshake of the conv delay line.
interface pconv_line_buf_if #(
  parameter int PCONV_LEN = 18,
  parameter int TAPS = 53
);
  logic i_start;
  logic [1:0] i_layer_num;
  logic i_in_valid;
  logic [PCONV_LEN-1:0] i_pconv_in;
  logic o_in_ready;
  logic o_valid;
  logic i_out_ready;
  logic [PCONV_LEN*TAPS-1:0] o_pconv;
  logic [1:0] o_layer_num;
  logic [15:0] o_win_cnt;
  modport master (
    output i_start, i_layer_num, i_in_valid, i_pconv_in, i_out_ready,
    input o_in_ready, o_valid, o_pconv, o_layer_num, o_win_cnt
  );
  modport slave (
    input i_start, i_layer_num, i_in_valid, i_pconv_in, i_out_ready,
    output o_in_ready, o_valid, o_pconv, o_layer_num, o_win_cnt
  );
endinterface

// File: rtl/pconv_line_buf.sv
// pconv_line_buf: 53-deep partial-sum delay line feeding conv; PCONV_ZERO_CLEAR_EN zeroes the line on i_start.
module pconv_line_buf #(
  parameter int PCONV_LEN = 18,
  parameter int TAPS = 53
) (
  input logic i_clk,
  input logic i_rst,
  pconv_line_buf_if.slave b
);
  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
  state_t state;
  logic [5:0] fill, span, fill_inc;
  logic [1:0] layer;
  logic valid, in_ready, acc, hs;
  logic [15:0] win_cnt;
  logic [PCONV_LEN*TAPS-1:0] line;
  always_comb begin
    span = layer == 2'd1 ? 6'd23 : layer == 2'd2 ? 6'd7 : 6'd53;
    in_ready = state != IDLE && (!valid || b.i_out_ready) && !b.i_start;
    acc = b.i_in_valid && in_ready;
    hs = valid && b.i_out_ready;
    fill_inc = fill == span ? fill : fill + 6'd1;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      fill <= '0;
      layer <= '0;
      valid <= 1'b0;
      win_cnt <= '0;
      line <= '0;
    end else if (b.i_start) begin
      state <= FILL;
      fill <= '0;
      layer <= b.i_layer_num;
      valid <= 1'b0;
      win_cnt <= '0;
`ifdef PCONV_ZERO_CLEAR_EN
      line <= '0;
`else
      line <= line;
`endif
    end else begin
      if (hs) win_cnt <= win_cnt + 16'd1;
      if (acc) begin
        line <= {line[PCONV_LEN*(TAPS-1)-1:0], b.i_pconv_in};
        fill <= fill_inc;
      end
      // once fill sits at span, every acceptance yields a fresh window
      valid <= acc && fill_inc == span ? 1'b1 : hs ? 1'b0 : valid;
      if (acc && fill_inc == span) state <= STREAM;
    end
  end
  assign b.o_in_ready = in_ready;
  assign b.o_valid = valid;
  assign b.o_pconv = line;
  assign b.o_layer_num = layer;
  assign b.o_win_cnt = win_cnt;
endmodule

// File: tb/tb_pconv_line_buf.sv
// tb_pconv_line_buf: directed streams with a window scoreboard checked by an independent monitor.
module tb_pconv_line_buf;
  localparam int W = 18;
  typedef struct {
    logic [17:0] e0, em, el;
    int m;
    logic [1:0] layer;
  } win_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pconv_line_buf_if #(.PCONV_LEN(W), .TAPS(53)) b();
  pconv_line_buf #(.PCONV_LEN(W), .TAPS(53)) dut (.i_clk(clk), .i_rst(rst), .b(b));
  win_t sb[$];
  win_t mw;
  logic [17:0] hist[$];
  logic [W*53-1:0] snap;
  int vecs = 0, errs = 0, nwin = 0, span = 53;
  logic [1:0] cur_layer = 2'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] tap(input int k);
    return b.o_pconv[W*k +: W];
  endfunction

  always @(negedge clk) begin
    if (!rst && b.o_valid && b.i_out_ready) begin
      nwin++;
      if (sb.size() == 0) chk("unexpected_window", 64'd1, 64'd0);
      else begin
        mw = sb.pop_front();
        chk("win_tap0", tap(0), mw.e0);
        chk("win_tap_mid", tap(mw.m), mw.em);
        chk("win_tap_last", tap(2 * mw.m), mw.el);
        chk("win_layer", b.o_layer_num, mw.layer);
      end
    end
  end

  task automatic record(input logic [17:0] v);
    int n, m;
    hist.push_back(v);
    n = hist.size();
    m = (span - 1) / 2;
    if (n >= span) sb.push_back('{v, hist[n-1-m], hist[n-1-2*m], m, cur_layer});
  endtask

  task automatic send(input logic [17:0] v);
    int t = 0;
    b.i_in_valid = 1'b1;
    b.i_pconv_in = v;
    @(negedge clk);
    while (!b.o_in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("accept_timeout", 64'(t >= 100), 64'd0);
    if (t < 100) record(v);
    @(posedge clk); #1;
    b.i_in_valid = 1'b0;
  endtask

  task automatic start(input logic [1:0] l);
    @(posedge clk); #1;
    b.i_start = 1'b1;
    b.i_layer_num = l;
    @(negedge clk);
    chk("ready_on_start", b.o_in_ready, 64'd0);
    @(posedge clk); #1;
    b.i_start = 1'b0;
    hist.delete();
    sb.delete();
    nwin = 0;
    cur_layer = l;
    span = l == 2'd1 ? 23 : l == 2'd2 ? 7 : 53;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    b.i_start = 1'b0;
    b.i_layer_num = 2'd0;
    b.i_in_valid = 1'b0;
    b.i_pconv_in = '0;
    b.i_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", b.o_in_ready, 64'd0);
    chk("rst_valid", b.o_valid, 64'd0);
    chk("rst_pconv_nonzero", 64'(|b.o_pconv), 64'd0);
    chk("rst_layer", b.o_layer_num, 64'd0);
    chk("rst_win_cnt", b.o_win_cnt, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    // layer 2: samples 1..10 give four windows
    start(2'd2);
    for (int i = 1; i <= 10; i++) send(18'(i));
    repeat (2) @(posedge clk); #1;
    chk("l2_win_cnt", b.o_win_cnt, 64'd4);
    chk("l2_windows_seen", 64'(nwin), 64'd4);
    chk("l2_valid_low", b.o_valid, 64'd0);
    // layer 0: full 53 span
    start(2'd0);
    for (int i = 0; i < 52; i++) send(18'(i));
    chk("l0_no_early_valid", b.o_valid, 64'd0);
    send(18'd52);
    chk("l0_valid", b.o_valid, 64'd1);
    chk("l0_e0", tap(0), 64'd52);
    chk("l0_e26", tap(26), 64'd26);
    chk("l0_e52", tap(52), 64'd0);
    // layer 1 with backpressure on the first window
    start(2'd1);
    for (int i = 1; i <= 22; i++) send(18'(i));
    b.i_out_ready = 1'b0;
    send(18'd23);
    snap = b.o_pconv;
    b.i_in_valid = 1'b1;
    b.i_pconv_in = 18'd24;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", b.o_in_ready, 64'd0);
      chk("bp_valid", b.o_valid, 64'd1);
      chk("bp_pconv_changed", 64'(b.o_pconv != snap), 64'd0);
    end
    @(posedge clk); #1;
    b.i_out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", b.o_in_ready, 64'd1);
    chk("release_valid", b.o_valid, 64'd1);
    record(18'd24);
    @(posedge clk); #1;
    b.i_in_valid = 1'b0;
    chk("release_win_cnt", b.o_win_cnt, 64'd1);
    chk("release_tap0", tap(0), 64'd24);
    chk("release_valid_kept", b.o_valid, 64'd1);
    // restart mid-stream into layer 2 while a window is held
    b.i_out_ready = 1'b0;
    b.i_in_valid = 1'b1;
    b.i_pconv_in = 18'd99;
    start(2'd2);
    b.i_in_valid = 1'b0;
    chk("restart_valid", b.o_valid, 64'd0);
    chk("restart_layer", b.o_layer_num, 64'd2);
    chk("restart_win_cnt", b.o_win_cnt, 64'd0);
    chk("restart_rejected", 64'(tap(0) == 18'd99), 64'd0);
    b.i_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(18'(100 + i));
    chk("restart_no_early", b.o_valid, 64'd0);
    send(18'd106);
    chk("restart_valid_up", b.o_valid, 64'd1);
    chk("restart_layer_out", b.o_layer_num, 64'd2);
    send(18'd107);
    // reset together with start in STREAM
    rst = 1'b1;
    b.i_start = 1'b1;
    b.i_layer_num = 2'd1;
    b.i_in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    b.i_start = 1'b0;
    sb.delete();
    chk("mid_rst_in_ready", b.o_in_ready, 64'd0);
    chk("mid_rst_valid", b.o_valid, 64'd0);
    chk("mid_rst_pconv_nonzero", 64'(|b.o_pconv), 64'd0);
    chk("mid_rst_layer", b.o_layer_num, 64'd0);
    chk("mid_rst_win_cnt", b.o_win_cnt, 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", b.o_in_ready, 64'd0);
    end
    b.i_in_valid = 1'b0;
    // negative samples pass bit-exact
    start(2'd2);
`ifdef PCONV_ZERO_CLEAR_EN
    chk("zero_clear_nonzero", 64'(|b.o_pconv), 64'd0);
`endif
    send(18'h20000);
    send(18'h3FFFF);
    chk("neg_e1", tap(1), 64'h20000);
    chk("neg_e0", tap(0), 64'h3FFFF);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/pconv_line_buf.md
# pconv_line_buf

Delay-line buffer directly upstream of `conv`. It accepts a stream of 18-bit signed partial-convolution samples and holds the last 53 of them. It presents all 53 as the flat `o_pconv` bus that `conv` taps at layer-dependent offsets: 0/26/52, 0/11/22 or 0/3/6. It suppresses output until enough samples have arrived for the current layer's tap span, and applies valid/ready flow control on both sides.

## Interface
- `PCONV_LEN`, default 18: width of one partial sum, two's complement.
- `TAPS`, default 53: delay-line depth.
- `i_clk`, input, 1: clock; all logic is on the rising edge.
- `i_rst`, input, 1: synchronous, active-high reset.
- `i_start`, input, 1: one-cycle pulse that begins a new layer pass.
- `i_layer_num`, input, 2: layer select, latched on `i_start`.
- `i_in_valid`, input, 1: the input sample is valid.
- `i_pconv_in`, input, `PCONV_LEN`: the input partial sum.
- `o_in_ready`, output, 1: the block can accept a sample this cycle.
- `o_valid`, output, 1: the `o_pconv` window is valid for the latched layer.
- `i_out_ready`, input, 1: the downstream `conv` consumer takes the window.
- `o_pconv`, output, `PCONV_LEN*TAPS`: entry k occupies bits `[PCONV_LEN*k +: PCONV_LEN]`.
- `o_layer_num`, output, 2: the latched layer, which feeds `conv.layer_num`.
- `o_win_cnt`, output, 16: number of windows consumed since the last `i_start`.

## Operation
- **Entry ordering:** entry 0 is the newest accepted sample. Entry k is the sample accepted k acceptances earlier.
- **Acceptance:** a sample is accepted when `i_in_valid && o_in_ready`.
  - On acceptance, entry k takes entry k-1 for k = 52 down to 1, and entry 0 takes `i_pconv_in`.
  - `o_in_ready = (state != IDLE) && (!o_valid || i_out_ready)`.
- **Span S** per latched layer:
  - layer 0: S = 53
  - layer 1: S = 23
  - layer 2: S = 7
  - layer 3: treated as layer 0, S = 53
- **Fill counter `fill`** (6 bits):
  - Cleared on `i_start`.
  - Incremented on each acceptance, saturating at S.
- **States:**
  - **IDLE:** the reset state. `o_in_ready = 0`, `o_valid = 0`. On `i_start`, go to FILL.
  - **FILL:** accepts samples. When an acceptance brings `fill` to S, set `o_valid` the next cycle and go to STREAM.
  - **STREAM:** every acceptance produces a new window.
    - `o_valid` is set after the shift and cleared after a handshake (`o_valid && i_out_ready`) in which no new sample is accepted.
    - A simultaneous handshake and acceptance keeps `o_valid = 1` with the new window.
- **`i_start` in any state:**
  - Clears `fill`, `o_valid` and `o_win_cnt`, and latches `i_layer_num`.
  - Goes to FILL.
  - Any sample presented in the same cycle is not accepted; `o_in_ready` is forced to 0 that cycle.
- **`o_win_cnt`:** increments on each output handshake and wraps from 0xFFFF to 0.
- **No arithmetic:** samples pass through bit-exact. Sign extension is done in `conv`.

## Timing
- **Reset values** after `i_rst`:
  - `o_in_ready = 0`, `o_valid = 0`, `o_pconv = 0`, `o_layer_num = 0`, `o_win_cnt = 0`.
  - State is IDLE and `fill = 0`.
- **`i_rst` takes priority over `i_start`**, including mid-pass; the pass is abandoned.
- **First window latency:** `o_valid` rises on the cycle after the S-th acceptance following `i_start`.
- **Streaming latency:** 1 cycle from acceptance to an updated `o_pconv`.
- **Throughput:** one window per cycle when `i_in_valid` and `i_out_ready` are held high.
- **Window stability:** while `o_valid && !i_out_ready`, `o_pconv`, `o_valid` and `o_layer_num` hold stable, and `o_in_ready = 0`.
- **Ready has no combinational path from `i_in_valid`:** `o_in_ready` depends only on state, `o_valid` and `i_out_ready`.

## Configuration
- **`PCONV_ZERO_CLEAR_EN` defined:** `i_start` also zeroes all 53 entries, so `o_pconv` reads all-zero in the cycle after `i_start`.
- **`PCONV_ZERO_CLEAR_EN` undefined:** entries keep stale data across `i_start`. Only `fill` gating prevents stale windows from being emitted; this saves clear-mux area.
- **Identical in both builds:** all handshake and `o_valid` timing.

## Test plan
- **Layer 2 fill:** reset, then `i_start` with layer 2, then stream samples 1..10 with `i_out_ready = 1`.
  - `o_valid` first rises the cycle after sample 7, with entries 0/3/6 = 7/4/1.
  - A total of 4 windows is emitted and `o_win_cnt = 4`.
- **Layer 0 span:** layer 0, samples 0..52.
  - There is no `o_valid` before the 53rd acceptance.
  - The first window has entry 0 = 52, entry 26 = 26 and entry 52 = 0.
- **Backpressure:** layer 1, stream samples, and hold `i_out_ready = 0` for 5 cycles after the first window.
  - `o_in_ready = 0` and `o_pconv` is unchanged throughout.
  - On release, the next sample is accepted the same cycle as the handshake.
- **Restart mid-stream:** in STREAM with `fill = 23`, pulse `i_start` with layer 2 while `i_in_valid = 1`.
  - That sample is rejected and `o_valid` drops.
  - The next window appears only after 7 new acceptances, with `o_layer_num = 2`.
- **Reset mid-operation:** assert `i_rst` during STREAM, together with `i_start`.
  - All outputs are at their reset values next cycle and the state is IDLE.
  - `o_in_ready` stays 0 until a later `i_start`.
- **Negative passthrough:** input 0x20000 (-131072) followed by 0x3FFFF.
  - These appear bit-exact in entries 1 and 0.
  - With `PCONV_ZERO_CLEAR_EN` defined, entries read 0 immediately after `i_start`.
